// File: rtl/mux21_pkg.sv
// Shared types and defaults for the mux21 round-robin arbiter slice.
package mux21_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } state_e;

   localparam int unsigned MAX_BURST_DEF = 4;
   localparam int unsigned CNT_W_DEF     = 8;

   // Bits needed to count 0 .. max_burst-1 (never less than one bit).
   function automatic int unsigned burst_width(input int unsigned max_burst);
      return (max_burst < 2) ? 1 : $clog2(max_burst);
   endfunction

endpackage

// File: rtl/mux21.sv
// Plain 2:1 datapath mux: sel=0 picks din0, sel=1 picks din1.
module mux21 #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             sel,
   input  logic [WIDTH-1:0] din0,
   input  logic [WIDTH-1:0] din1,
   output logic [WIDTH-1:0] y_c
);

   assign y_c = sel ? din1 : din0;

endmodule

// File: rtl/mux21_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module mux21_sat_cnt #(
   parameter int unsigned    W   = 8,
   parameter logic [W-1:0]   MAX = '1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != MAX)) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/mux21_arbiter.sv
// Round-robin, burst-limited arbiter sharing one mux21 between two requesters.
// Define MUX21_ARB_STATS_EN to add the per-requester grant counters gnt_cnt0/gnt_cnt1.
module mux21_arbiter
   import mux21_pkg::*;
#(
   parameter int unsigned WIDTH     = 1,
   parameter int unsigned MAX_BURST = MAX_BURST_DEF,
   parameter int unsigned CNT_W     = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] din0,
   input  logic [WIDTH-1:0] din1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             sel,
   output logic [WIDTH-1:0] dout,
   output logic             dout_vld
`ifdef MUX21_ARB_STATS_EN
  ,output logic [CNT_W-1:0] gnt_cnt0,
   output logic [CNT_W-1:0] gnt_cnt1
`endif
);

   localparam int unsigned      BW         = burst_width(MAX_BURST);
   localparam logic [BW-1:0]    BURST_LAST = BW'(MAX_BURST - 1);

   if ((MAX_BURST < 1) || (CNT_W < 1)) begin : g_bad_cfg
      $error("mux21_arbiter: MAX_BURST and CNT_W must be at least 1");
   end

   state_e           state;
   state_e           next_state;
   logic             prio;
   logic             enter0;
   logic             enter1;
   logic             burst_clr;
   logic             burst_inc;
   logic [BW-1:0]    burst_cnt;
   logic [WIDTH-1:0] mux_c;
   logic             vld_c;

   // Next-state logic: tie goes to prio, owner yields on release or burst expiry.
   always_comb begin
      next_state = state;
      enter0     = 1'b0;
      enter1     = 1'b0;
      burst_clr  = 1'b0;
      burst_inc  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req0 && req1)  next_state = prio ? ST_OWN1 : ST_OWN0;
            else if (req0)     next_state = ST_OWN0;
            else if (req1)     next_state = ST_OWN1;
         end
         ST_OWN0: begin
            if (!req0)                               next_state = req1 ? ST_OWN1 : ST_IDLE;
            else if (req1 && burst_cnt == BURST_LAST) next_state = ST_OWN1;
         end
         ST_OWN1: begin
            if (!req1)                               next_state = req0 ? ST_OWN0 : ST_IDLE;
            else if (req0 && burst_cnt == BURST_LAST) next_state = ST_OWN0;
         end
         default: next_state = ST_IDLE;
      endcase
      enter0    = (next_state == ST_OWN0) && (state != ST_OWN0);
      enter1    = (next_state == ST_OWN1) && (state != ST_OWN1);
      burst_clr = enter0 || enter1 || (next_state == ST_IDLE);
      burst_inc = (state != ST_IDLE);
   end

   assign vld_c = (gnt0 && req0) || (gnt1 && req1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         gnt0     <= 1'b0;
         gnt1     <= 1'b0;
         sel      <= 1'b0;
         prio     <= 1'b0;
         dout     <= '0;
         dout_vld <= 1'b0;
      end else begin
         state    <= next_state;
         gnt0     <= (next_state == ST_OWN0);
         gnt1     <= (next_state == ST_OWN1);
         dout_vld <= vld_c;
         if (enter0) begin
            sel  <= 1'b0;
            prio <= 1'b1;
         end else if (enter1) begin
            sel  <= 1'b1;
            prio <= 1'b0;
         end
         if (vld_c) dout <= mux_c;
      end
   end

   mux21 #(.WIDTH(WIDTH)) u_mux (
      .sel  (sel),
      .din0 (din0),
      .din1 (din1),
      .y_c  (mux_c)
   );

   // Counts owned cycles of the current owner; saturates at the handover point.
   mux21_sat_cnt #(.W(BW), .MAX(BURST_LAST)) u_burst_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (burst_clr),
      .inc   (burst_inc),
      .cnt   (burst_cnt)
   );

`ifdef MUX21_ARB_STATS_EN
   mux21_sat_cnt #(.W(CNT_W)) u_gnt_cnt0 (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (1'b0),
      .inc   (enter0),
      .cnt   (gnt_cnt0)
   );

   mux21_sat_cnt #(.W(CNT_W)) u_gnt_cnt1 (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (1'b0),
      .inc   (enter1),
      .cnt   (gnt_cnt1)
   );
`else
   // Statistics disabled: grant entries are not counted.
`endif

endmodule

// File: tb/tb_mux21_arbiter.sv
// Directed bench for mux21_arbiter: ownership model checked every cycle plus literal spot checks.
// Honours MUX21_ARB_STATS_EN to connect and check the grant counters.
module tb_mux21_arbiter;

   localparam int unsigned TB_WIDTH = 1;
   localparam int          TB_BURST = 4;
   localparam int unsigned TB_CNT_W = 2;
   localparam int          CNT_TOP  = (1 << TB_CNT_W) - 1;

   logic clk = 1'b0;
   logic rst_n;
   logic req0, req1;
   logic [TB_WIDTH-1:0] din0, din1;
   logic gnt0, gnt1, sel, dout_vld;
   logic [TB_WIDTH-1:0] dout;
`ifdef MUX21_ARB_STATS_EN
   logic [TB_CNT_W-1:0] gnt_cnt0, gnt_cnt1;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mux21_arbiter #(.WIDTH(TB_WIDTH), .MAX_BURST(TB_BURST), .CNT_W(TB_CNT_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req0     (req0),
      .req1     (req1),
      .din0     (din0),
      .din1     (din1),
      .gnt0     (gnt0),
      .gnt1     (gnt1),
      .sel      (sel),
      .dout     (dout),
      .dout_vld (dout_vld)
`ifdef MUX21_ARB_STATS_EN
     ,.gnt_cnt0 (gnt_cnt0),
      .gnt_cnt1 (gnt_cnt1)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Ownership model: who holds the mux, how long, and who wins the next tie.
   int m_owner;      // -1 = nobody
   int m_run;        // cycles the current owner has held the mux, capped at TB_BURST
   int m_tie;        // requester that wins a simultaneous request from idle
   int m_sel;
   int m_vld;
   int m_dout;
   int m_cnt [2];
   int m_next;
   int rq [2];
   int dd [2];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_owner = -1; m_run = 0; m_tie = 0; m_sel = 0;
         m_vld = 0; m_dout = 0; m_cnt[0] = 0; m_cnt[1] = 0;
      end else begin
         rq[0] = int'(req0); rq[1] = int'(req1);
         dd[0] = int'(din0); dd[1] = int'(din1);
         m_vld = (m_owner >= 0 && rq[m_owner] != 0) ? 1 : 0;
         if (m_vld != 0) m_dout = dd[m_owner];
         if (m_owner < 0)
            m_next = (rq[0] != 0 && rq[1] != 0) ? m_tie : (rq[0] != 0) ? 0 : (rq[1] != 0) ? 1 : -1;
         else if (rq[m_owner] == 0)
            m_next = (rq[1-m_owner] != 0) ? 1 - m_owner : -1;
         else if (rq[1-m_owner] != 0 && m_run >= TB_BURST)
            m_next = 1 - m_owner;
         else
            m_next = m_owner;
         if (m_next >= 0 && m_next != m_owner) begin
            m_run = 1;
            m_tie = 1 - m_next;
            m_sel = m_next;
            if (m_cnt[m_next] < CNT_TOP) m_cnt[m_next]++;
         end else if (m_next >= 0) begin
            m_run = (m_run < TB_BURST) ? m_run + 1 : TB_BURST;
         end else begin
            m_run = 0;
         end
         m_owner = m_next;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      check("gnt0", 32'(gnt0), 32'(m_owner == 0));
      check("gnt1", 32'(gnt1), 32'(m_owner == 1));
      check("one_hot", 32'(gnt0 & gnt1), 32'd0);
      check("sel", 32'(sel), 32'(m_sel));
      check("dout_vld", 32'(dout_vld), 32'(m_vld));
      check("dout", 32'(dout), 32'(m_dout));
`ifdef MUX21_ARB_STATS_EN
      check("gnt_cnt0", 32'(gnt_cnt0), 32'(m_cnt[0]));
      check("gnt_cnt1", 32'(gnt_cnt1), 32'(m_cnt[1]));
`endif
   end

   logic [3:0] vec [0:23];

   initial begin
      vec = '{4'b1010, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b1000, 4'b1101, 4'b1110,
              4'b0111, 4'b0110, 4'b0101, 4'b1111, 4'b1100, 4'b1111, 4'b1110, 4'b1101,
              4'b0000, 4'b1100, 4'b1100, 4'b0011, 4'b0100, 4'b0110, 4'b0000, 4'b0000};

      // Reset with both requesting: nothing granted until release.
      rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1; din0 = 1'b1; din1 = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_gnt0", 32'(gnt0), 32'd0);
      check("rst_gnt1", 32'(gnt1), 32'd0);
      check("rst_sel", 32'(sel), 32'd0);
      check("rst_vld", 32'(dout_vld), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_gnt0", 32'(gnt0), 32'd1);

      // Contention: four cycles each, alternating.
      for (int i = 0; i < 8; i++) begin
         check("burst_gnt0", 32'(gnt0), 32'(i < 4));
         check("burst_gnt1", 32'(gnt1), 32'(i >= 4));
         @(negedge clk);
      end
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);

      // Single requester 1.
      req1 = 1'b1; din1 = 1'b1;
      @(negedge clk);
      check("single_gnt1", 32'(gnt1), 32'd1);
      check("single_sel", 32'(sel), 32'd1);
      @(negedge clk);
      check("single_dout", 32'(dout), 32'd1);
      check("single_vld", 32'(dout_vld), 32'd1);
      req1 = 1'b0;
      @(negedge clk);
      check("idle_gnt1", 32'(gnt1), 32'd0);
      check("idle_sel_hold", 32'(sel), 32'd1);

      // Early release: owner 0 drops while 1 waits, handover without an idle cycle.
      req0 = 1'b1;
      @(negedge clk);
      req1 = 1'b1;
      @(negedge clk);
      check("early_gnt0", 32'(gnt0), 32'd1);
      req0 = 1'b0;
      @(negedge clk);
      check("early_gnt1", 32'(gnt1), 32'd1);
      check("early_gnt0_off", 32'(gnt0), 32'd0);

      // Asynchronous reset between edges while requester 1 owns.
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("areset_gnt1", 32'(gnt1), 32'd0);
      check("areset_sel", 32'(sel), 32'd0);
      check("areset_vld", 32'(dout_vld), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Mixed directed vectors {req0, req1, din0, din1}.
      for (int i = 0; i < 24; i++) begin
         {req0, req1, din0, din1} = vec[i];
         @(negedge clk);
      end

`ifdef MUX21_ARB_STATS_EN
      // Five separate grants to requester 0 saturate a 2-bit counter at 3.
      rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         req0 = 1'b1;
         @(negedge clk);
         req0 = 1'b0;
         @(negedge clk);
      end
      check("stats_cnt0_sat", 32'(gnt_cnt0), 32'd3);
      check("stats_cnt1_zero", 32'(gnt_cnt1), 32'd0);
`endif

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
